// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the polyphonic voice allocator: MIDI constants,
// the allocator FSM encoding and an index-width helper.
package voice_allocator_pkg;

    localparam int MIDI_W = 7;
    localparam logic [MIDI_W-1:0] MIDI_SILENT = 7'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Width of a voice index; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_scan_cmp.sv
// Examines one voice against the latched event note and folds it into the
// running match / first-free / oldest flags carried across the scan.
module voice_scan_cmp
    import voice_allocator_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int AGE_W = 8
) (
    input  logic [MIDI_W-1:0] note,
    input  logic [AGE_W-1:0]  age,
    input  logic [IDX_W-1:0]  idx,
    input  logic [MIDI_W-1:0] target,
    input  logic              match_in,
    input  logic [IDX_W-1:0]  match_idx_in,
    input  logic              free_in,
    input  logic [IDX_W-1:0]  free_idx_in,
    input  logic [AGE_W-1:0]  oldest_age_in,
    input  logic [IDX_W-1:0]  oldest_idx_in,
    output logic              match_out,
    output logic [IDX_W-1:0]  match_idx_out,
    output logic              free_out,
    output logic [IDX_W-1:0]  free_idx_out,
    output logic [AGE_W-1:0]  oldest_age_out,
    output logic [IDX_W-1:0]  oldest_idx_out
);

    // First hit wins for match/free; a strictly greater age wins for oldest so ties keep the lower index.
    always_comb begin
        match_out      = match_in;
        match_idx_out  = match_idx_in;
        free_out       = free_in;
        free_idx_out   = free_idx_in;
        oldest_age_out = oldest_age_in;
        oldest_idx_out = oldest_idx_in;
        if (!match_in && (note != MIDI_SILENT) && (note == target)) begin
            match_out     = 1'b1;
            match_idx_out = idx;
        end
        if (!free_in && (note == MIDI_SILENT)) begin
            free_out     = 1'b1;
            free_idx_out = idx;
        end
        if (age > oldest_age_in) begin
            oldest_age_out = age;
            oldest_idx_out = idx;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: maps MIDI note-on/off events onto NVOICES voices,
// preferring retrigger, then a free voice, then stealing the oldest voice.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NVOICES = 8,
    parameter int AGE_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_note_on,
    input  logic [MIDI_W-1:0]             i_midi,
    input  logic                          i_all_off,
    output logic [MIDI_W*NVOICES-1:0]     o_voice_midi,
    output logic [NVOICES-1:0]            o_voice_active,
    output logic                          o_done,
    output logic                          o_stolen,
    output logic [idx_bits(NVOICES)-1:0]  o_voice_idx
);

    localparam int IDX_W = idx_bits(NVOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    state_t state, next_state;
    logic scan_en, commit_en, accept;

    logic [MIDI_W-1:0] notes [NVOICES];
    logic [AGE_W-1:0]  ages  [NVOICES];

    logic              lat_on;
    logic [MIDI_W-1:0] lat_note;
    logic [IDX_W-1:0]  idx;

    logic              match_found, free_found;
    logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;
    logic              nx_match, nx_free;
    logic [IDX_W-1:0]  nx_match_idx, nx_free_idx, nx_old_idx;
    logic [AGE_W-1:0]  nx_old_age;

    logic              hit, steal, age_adv;
    logic [IDX_W-1:0]  tgt_idx;
    logic [MIDI_W-1:0] tgt_note;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic; panic always forces IDLE
    always_comb begin
        next_state = state;
        if (i_all_off) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (i_valid) next_state = ST_SCAN;
                ST_SCAN:   if (idx == LAST_IDX) next_state = ST_COMMIT;
                ST_COMMIT: next_state = ST_IDLE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: handshake and phase enables
    always_comb begin
        o_ready   = 1'b0;
        scan_en   = 1'b0;
        commit_en = 1'b0;
        case (state)
            ST_IDLE:   o_ready   = 1'b1;
            ST_SCAN:   scan_en   = !i_all_off;
            ST_COMMIT: commit_en = !i_all_off;
            default:   o_ready   = 1'b0;
        endcase
    end

    assign accept = o_ready && i_valid && !i_all_off;

    voice_scan_cmp #(.IDX_W(IDX_W), .AGE_W(AGE_W)) u_cmp (
        .note           (notes[idx]),
        .age            (ages[idx]),
        .idx            (idx),
        .target         (lat_note),
        .match_in       (match_found),
        .match_idx_in   (match_idx),
        .free_in        (free_found),
        .free_idx_in    (free_idx),
        .oldest_age_in  (old_age),
        .oldest_idx_in  (old_idx),
        .match_out      (nx_match),
        .match_idx_out  (nx_match_idx),
        .free_out       (nx_free),
        .free_idx_out   (nx_free_idx),
        .oldest_age_out (nx_old_age),
        .oldest_idx_out (nx_old_idx)
    );

    // Event latch and one-voice-per-cycle scan bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_on      <= 1'b0;
            lat_note    <= MIDI_SILENT;
            idx         <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_age     <= '0;
            old_idx     <= '0;
        end else if (accept) begin
            lat_on      <= i_note_on;
            lat_note    <= i_midi;
            idx         <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_age     <= '0;
            old_idx     <= '0;
        end else if (scan_en) begin
            match_found <= nx_match;
            match_idx   <= nx_match_idx;
            free_found  <= nx_free;
            free_idx    <= nx_free_idx;
            old_age     <= nx_old_age;
            old_idx     <= nx_old_idx;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
    end

    // Commit decision: which voice is written, with what note, and whether ages advance
    always_comb begin
        hit      = 1'b0;
        steal    = 1'b0;
        age_adv  = 1'b0;
        tgt_idx  = '0;
        tgt_note = MIDI_SILENT;
        if (lat_note != MIDI_SILENT) begin
            if (lat_on) begin
                hit      = 1'b1;
                age_adv  = 1'b1;
                tgt_note = lat_note;
                if (match_found)     tgt_idx = match_idx;
                else if (free_found) tgt_idx = free_idx;
                else begin
                    tgt_idx = old_idx;
                    steal   = 1'b1;
                end
            end else if (match_found) begin
                hit     = 1'b1;
                tgt_idx = match_idx;
            end
        end
    end

    // Voice note/age storage; panic clears everything in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NVOICES; k++) begin
                notes[k] <= MIDI_SILENT;
                ages[k]  <= '0;
            end
        end else if (i_all_off) begin
            for (int k = 0; k < NVOICES; k++) begin
                notes[k] <= MIDI_SILENT;
                ages[k]  <= '0;
            end
        end else if (commit_en) begin
            for (int k = 0; k < NVOICES; k++) begin
                if (hit && (tgt_idx == IDX_W'(k))) begin
                    notes[k] <= tgt_note;
                    ages[k]  <= '0;
                end else if (age_adv && (notes[k] != MIDI_SILENT) && (ages[k] != AGE_MAX)) begin
                    ages[k] <= ages[k] + 1'b1;
                end
            end
        end
    end

    // Registered commit status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_done      <= 1'b0;
            o_stolen    <= 1'b0;
            o_voice_idx <= '0;
        end else begin
            o_done   <= commit_en;
            o_stolen <= commit_en && steal;
            if (commit_en) o_voice_idx <= hit ? tgt_idx : '0;
        end
    end

    // Flatten the per-voice notes onto the packed output bus
    always_comb begin
        o_voice_midi   = '0;
        o_voice_active = '0;
        for (int k = 0; k < NVOICES; k++) begin
            o_voice_midi[k*MIDI_W +: MIDI_W] = notes[k];
            o_voice_active[k]                = (notes[k] != MIDI_SILENT);
        end
    end

endmodule
